timer_bank: RTL and testbench
=============================

# timer_bank

Memory-mapped machine-timer peripheral generalising the single mtime/mtimecmp pair into a 64-bit `mtime` counter with programmable prescaler and `CHANNELS` independent compare channels. Each channel has a one-shot level mode or a periodic auto-reload mode with sticky write-1-to-clear pending bits. It sits on the core's data-memory port in the `clk24` domain. It drives `mip_mtip` and a per-channel interrupt vector.

## Interface

Parameters:
- `CHANNELS`, 2: number of compare channels, 1–8.
- `PRESCALE_WIDTH`, 16: width of the prescaler register and counter, 1–32.
- `BASE_ADDRESS`, 32'h80000000: byte address of the register window. Must be 256-byte aligned; the window is 256 bytes.

Ports:
- `clk24`  in  1: core clock. Every register updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `memory_address`  in  32: byte address of the current core access.
- `memory_write_value`  in  32: write data, already byte-lane aligned.
- `memory_write_sections`  in  4: byte write enables. 0 means no write.
- `read_value`  out  32: registered read data for the previous cycle's address.
- `read_hit`  out  1: registered; 1 when the previous cycle's address was inside the window.
- `irq`  out  `CHANNELS`: per-channel interrupt lines.
- `mip_mtip`  out  1: OR of `irq`.

## Operation

Register map. Offsets are from `BASE_ADDRESS`; `n` is the channel index.
- 0x00 `MTIME`, 0x04 `MTIMEH`: the 64-bit counter.
- 0x08 `PRESCALE`: `PRESCALE_WIDTH` bits wide. Upper bits read 0.
- 0x0C `STATUS`: bit `n` is `pending[n]`. Write 1 to clear; writing 0 has no effect.
- 0x10+0x10·n `CMP`, +0x04 `CMPH`: the 64-bit compare value `cmp[n]`.
- +0x08 `PERIOD`: 32-bit reload increment.
- +0x0C `CTRL`: bit0 = enable, bit1 = periodic. Other bits read 0.
- Unmapped offsets, and channels ≥ `CHANNELS`: reads return 0, writes are ignored.
- All writes honour the byte enables.

Prescaler:
- A counter `pcnt` counts up. A tick occurs when `pcnt == PRESCALE`; on that cycle `pcnt` returns to 0.
- `PRESCALE = 0` gives a tick every cycle.
- Writing `PRESCALE` also clears `pcnt`.

Counter:
- On a tick, `mtime` increments by 1, mod 2^64: all-ones wraps to 0.
- A write to `MTIME` or `MTIMEH` in a cycle replaces the written bytes. The increment is suppressed for that cycle, tick or not.

Per-channel match: `match[n] = enable[n] & (mtime >= cmp[n])`, an unsigned 64-bit compare on the current register values.

One-shot mode (periodic = 0):
- `irq[n]` is registered `match[n]`, so it is level-sensitive.
- Software deasserts it by raising `cmp[n]` or clearing enable.
- `pending[n]` is also set on match.

Periodic mode (periodic = 1):
- On a cycle with `match[n]`: `cmp[n] <= cmp[n] + PERIOD`, zero-extended and mod 2^64, and `pending[n] <= 1`.
- `irq[n]` is registered `pending[n]`.
- If `PERIOD = 0`, `cmp` is unchanged, so `pending` re-sets every cycle while matching.

Priorities:
- A software write to `CMP`/`CMPH` in the same cycle as a reload: the software bytes win and the reload is dropped.
- A `STATUS` write-1-to-clear in the same cycle as a set on the same bit: the set wins.

Reset values:
- `mtime` = 0, `pcnt` = 0, `PRESCALE` = 0.
- `cmp` = all ones, `PERIOD` = 0, `CTRL` = 0, `pending` = 0.
- `read_value` = 0, `read_hit` = 0, `irq` = 0, `mip_mtip` = 0.
- `reset` overrides any write in the same cycle.

## Timing

- Read latency is 1 cycle. `read_value`/`read_hit` reflect register state at the edge that samples the address, i.e. before that cycle's writes.
- Writes take effect at the edge ending the cycle in which they are presented.
- Match-to-`irq` latency:
  - `match[n]` is evaluated in cycle t.
  - `irq[n]` is asserted after edge t+1 in both modes.
  - In periodic mode, the `pending` set and the `cmp` reload both land at edge t+1.
- `mip_mtip` is combinational from `irq`, so it has the same cycle as `irq`.
- No back-pressure: every access completes in one cycle.

## Configuration

Macro: `TIMER_BANK_PERIODIC_EN`.
- Defined: periodic mode, the `PERIOD` registers and the reload adders are present.
- Undefined:
  - `PERIOD` and `CTRL` bit1 are not implemented: they read 0 and writes are ignored.
  - All channels operate in one-shot mode.
  - `pending`/`STATUS` remain implemented.

## Test plan

- **Reset and count.** Reset, then 10 idle cycles with `PRESCALE` = 0 → `MTIME` reads 10, `MTIMEH` reads 0. Reading `CMP`/`CMPH` of channel 0 → 0xFFFFFFFF each. `irq` = 0.
- **Prescaler.** Write `PRESCALE` = 3 → `mtime` advances once every 4 cycles. Across 40 cycles it advances by exactly 10.
- **Wraparound and byte writes.**
  - Write `MTIMEH` = 0xFFFFFFFF and `MTIME` = 0xFFFFFFFE with `PRESCALE` = 0; one cycle after the last write `MTIME` reads 0xFFFFFFFE, and two cycles later `mtime` = 0.
  - A byte write of 0xAB to `MTIME` + 1 (sections 4'b0010) changes only bits 15:8.
- **One-shot.** Channel 1: `CMP` = 20, `CMPH` = 0, enable = 1 → `irq[1]` rises one cycle after `mtime` reaches 20, with `mip_mtip` = 1. Writing `CMP` = 1000 drops `irq[1]` one cycle later.
- **Periodic.** Channel 0: `CMP` = 8, `PERIOD` = 5, `CTRL` = 3.
  - `pending[0]` sets at mtime 8, 13, 18; `CMP` reads 13, 18, 23 in turn.
  - A `STATUS` write of 1 clears `irq[0]` unless it collides with a set, in which case it stays 1.
  - Without `TIMER_BANK_PERIODIC_EN`, `CTRL` reads 1 and `PERIOD` reads 0.
- **Reset mid-operation.** Assert `reset` while `irq` = 2'b11 and a `CMP` write occurs in the same cycle → next cycle all state is at reset values and the write is discarded.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank: 64-bit mtime counter with prescaler and CHANNELS compare channels on the data bus.
// Define TIMER_BANK_PERIODIC_EN to add periodic auto-reload (PERIOD registers and CTRL bit1).
module timer_bank #(
    parameter int          CHANNELS       = 2,
    parameter int          PRESCALE_WIDTH = 16,
    parameter logic [31:0] BASE_ADDRESS   = 32'h80000000
) (
    input  logic                clk24,
    input  logic                reset,
    input  logic [31:0]         memory_address,
    input  logic [31:0]         memory_write_value,
    input  logic [3:0]          memory_write_sections,
    output logic [31:0]         read_value,
    output logic                read_hit,
    output logic [CHANNELS-1:0] irq,
    output logic                mip_mtip
);
    localparam logic [4:0] NUM_CH = 5'(CHANNELS);

    logic [63:0]               mtime;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic [63:0]               cmp [CHANNELS];
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       periodic;
    logic [CHANNELS-1:0]       pending;
    logic [CHANNELS-1:0]       match;
    logic [CHANNELS-1:0]       clr_pending;
    logic [CHANNELS-1:0]       pending_next;

    logic                      in_window;
    logic                      wr;
    logic [5:0]                word;
    logic [1:0]                sub;
    logic [3:0]                ch_sel;
    logic                      ch_valid;
    logic                      tick;
    logic [31:0]               be_mask;
    logic                      wr_mtime_lo;
    logic                      wr_mtime_hi;
    logic                      wr_prescale;
    logic                      wr_status;
    logic [CHANNELS-1:0]       wr_cmp_lo;
    logic [CHANNELS-1:0]       wr_cmp_hi;
    logic [CHANNELS-1:0]       wr_ctrl;
    logic [31:0]               rdata;
    logic                      unused_addr_bits;

`ifdef TIMER_BANK_PERIODIC_EN
    logic [31:0]               period [CHANNELS];
    logic [CHANNELS-1:0]       wr_period;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    // Data is already lane aligned, so the low address bits carry no information.
    assign unused_addr_bits = ^memory_address[1:0];

    assign in_window   = memory_address[31:8] == BASE_ADDRESS[31:8];
    assign wr          = in_window && (memory_write_sections != 4'b0000);
    assign word        = memory_address[7:2];
    assign sub         = memory_address[3:2];
    assign ch_sel      = memory_address[7:4] - 4'd1;
    assign ch_valid    = (memory_address[7:4] != 4'd0) && ({1'b0, ch_sel} < NUM_CH);
    assign be_mask     = {{8{memory_write_sections[3]}}, {8{memory_write_sections[2]}},
                          {8{memory_write_sections[1]}}, {8{memory_write_sections[0]}}};
    assign wr_mtime_lo = wr && (word == 6'd0);
    assign wr_mtime_hi = wr && (word == 6'd1);
    assign wr_prescale = wr && (word == 6'd2);
    assign wr_status   = wr && (word == 6'd3);
    assign tick        = pcnt == prescale;

    always_comb begin
        wr_cmp_lo = '0;
        wr_cmp_hi = '0;
        wr_ctrl   = '0;
`ifdef TIMER_BANK_PERIODIC_EN
        wr_period = '0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr && ch_valid && (ch_sel == 4'(i))) begin
                wr_cmp_lo[i] = sub == 2'd0;
                wr_cmp_hi[i] = sub == 2'd1;
                wr_ctrl[i]   = sub == 2'd3;
`ifdef TIMER_BANK_PERIODIC_EN
                wr_period[i] = sub == 2'd2;
`endif
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            match[i] = enable[i] && (mtime >= cmp[i]);
        end
    end

    // A set in the same cycle as a write-1-to-clear wins.
    assign clr_pending  = wr_status ? (memory_write_value[CHANNELS-1:0] & be_mask[CHANNELS-1:0]) : '0;
    assign pending_next = match | (pending & ~clr_pending);

`ifndef TIMER_BANK_PERIODIC_EN
    assign periodic = '0;
`endif

    always_comb begin
        rdata = '0;
        case (word)
            6'd0: rdata = mtime[31:0];
            6'd1: rdata = mtime[63:32];
            6'd2: rdata[PRESCALE_WIDTH-1:0] = prescale;
            6'd3: rdata[CHANNELS-1:0] = pending;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (ch_valid && (ch_sel == 4'(i))) begin
                        case (sub)
                            2'd0: rdata = cmp[i][31:0];
                            2'd1: rdata = cmp[i][63:32];
`ifdef TIMER_BANK_PERIODIC_EN
                            2'd2: rdata = period[i];
`endif
                            2'd3: rdata = {30'b0, periodic[i], enable[i]};
                            default: rdata = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk24) begin
        if (reset) begin
            mtime      <= '0;
            pcnt       <= '0;
            prescale   <= '0;
            enable     <= '0;
            pending    <= '0;
            irq        <= '0;
            read_value <= '0;
            read_hit   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cmp[i] <= '1;
`ifdef TIMER_BANK_PERIODIC_EN
                period[i]   <= '0;
                periodic[i] <= 1'b0;
`endif
            end
        end else begin
            read_value <= rdata;
            read_hit   <= in_window;

            if (wr_prescale) begin
                prescale <= PRESCALE_WIDTH'(merge_bytes(32'(prescale), memory_write_value,
                                                        memory_write_sections));
                pcnt     <= '0;
            end else if (tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PRESCALE_WIDTH'(1);
            end

            // A software write to either half freezes the count for that cycle.
            if (wr_mtime_lo) begin
                mtime[31:0] <= merge_bytes(mtime[31:0], memory_write_value, memory_write_sections);
            end
            if (wr_mtime_hi) begin
                mtime[63:32] <= merge_bytes(mtime[63:32], memory_write_value, memory_write_sections);
            end
            if (!wr_mtime_lo && !wr_mtime_hi && tick) begin
                mtime <= mtime + 64'd1;
            end

            pending <= pending_next;

            for (int i = 0; i < CHANNELS; i++) begin
                irq[i] <= periodic[i] ? pending_next[i] : match[i];
                if (wr_ctrl[i] && memory_write_sections[0]) begin
                    enable[i] <= memory_write_value[0];
`ifdef TIMER_BANK_PERIODIC_EN
                    periodic[i] <= memory_write_value[1];
`endif
                end
                if (wr_cmp_lo[i]) begin
                    cmp[i][31:0] <= merge_bytes(cmp[i][31:0], memory_write_value, memory_write_sections);
                end
                if (wr_cmp_hi[i]) begin
                    cmp[i][63:32] <= merge_bytes(cmp[i][63:32], memory_write_value, memory_write_sections);
                end
`ifdef TIMER_BANK_PERIODIC_EN
                if (wr_period[i]) begin
                    period[i] <= merge_bytes(period[i], memory_write_value, memory_write_sections);
                end
                // Software bytes to either compare half drop the reload.
                if (!wr_cmp_lo[i] && !wr_cmp_hi[i] && periodic[i] && match[i]) begin
                    cmp[i] <= cmp[i] + {32'b0, period[i]};
                end
`endif
            end
        end
    end

    assign mip_mtip = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: stimulus queues expected read data, a negedge monitor checks it.
module tb_timer_bank;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk24 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] memory_address = 32'h0;
    logic [31:0] memory_write_value = 32'h0;
    logic [3:0]  memory_write_sections = 4'h0;
    logic [31:0] read_value;
    logic        read_hit;
    logic [1:0]  irq;
    logic        mip_mtip;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
        bit          check;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    timer_bank #(
        .CHANNELS      (2),
        .PRESCALE_WIDTH(16),
        .BASE_ADDRESS  (BASE)
    ) dut (
        .clk24                (clk24),
        .reset                (reset),
        .memory_address       (memory_address),
        .memory_write_value   (memory_write_value),
        .memory_write_sections(memory_write_sections),
        .read_value           (read_value),
        .read_hit             (read_hit),
        .irq                  (irq),
        .mip_mtip             (mip_mtip)
    );

    always #5 clk24 = ~clk24;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk24) begin
        if (read_hit === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_hit: got read_value %h expected no access", read_value);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.check) check_val(mon_e.name, read_value, mon_e.value);
            end
        end
    end

    task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                         input string name, input logic [31:0] exp, input bit chk);
        sb_t e;
        @(negedge clk24);
        memory_address        = addr;
        memory_write_value    = data;
        memory_write_sections = be;
        if (addr[31:8] == BASE[31:8]) begin
            e.name  = name;
            e.value = exp;
            e.check = chk;
            sb_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        drive(BASE + {24'h0, off}, data, 4'hF, "write", 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] off, input string name, input logic [31:0] exp);
        drive(BASE + {24'h0, off}, 32'h0, 4'h0, name, exp, 1'b1);
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 4'h0, "idle", 32'h0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk24);
        @(negedge clk24);
        reset = 1'b0;

        // Reset and free-running count with PRESCALE = 0
        repeat (9) idle();
        check_val("read_hit_outside", {31'b0, read_hit}, 32'd0);
        check_val("irq_after_reset", {30'b0, irq}, 32'd0);
        check_val("mip_after_reset", {31'b0, mip_mtip}, 32'd0);
        rd(8'h00, "mtime_after_10", 32'd10);
        rd(8'h04, "mtimeh_after_10", 32'd0);
        rd(8'h10, "cmp0_reset", 32'hFFFF_FFFF);
        rd(8'h14, "cmph0_reset", 32'hFFFF_FFFF);

        // Prescaler of 3: one tick every 4 cycles
        wr(8'h08, 32'd3);
        rd(8'h00, "presc_start", 32'd15);
        repeat (2) idle();
        rd(8'h00, "presc_no_tick", 32'd15);
        rd(8'h00, "presc_tick", 32'd16);
        repeat (35) idle();
        rd(8'h00, "presc_40_cycles", 32'd25);
        rd(8'h08, "prescale_read", 32'd3);

        // 64-bit wraparound and byte-lane writes
        wr(8'h08, 32'd0);
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h00, 32'hFFFF_FFFE);
        rd(8'h00, "wrap_fe", 32'hFFFF_FFFE);
        rd(8'h00, "wrap_ff", 32'hFFFF_FFFF);
        rd(8'h04, "wrap_hi_zero", 32'h0);
        rd(8'h00, "wrap_lo_one", 32'h1);
        drive(BASE + 32'h1, 32'h0000_AB00, 4'b0010, "write", 32'h0, 1'b0);
        rd(8'h00, "byte_write", 32'h0000_AB02);

        // One-shot on channel 1
        wr(8'h00, 32'd0);
        wr(8'h20, 32'd20);
        wr(8'h24, 32'd0);
        wr(8'h2C, 32'd1);
        repeat (17) idle();
        rd(8'h00, "mtime_at_cmp", 32'd20);
        check_val("irq_before_match", {30'b0, irq}, 32'd0);
        idle();
        check_val("irq1_oneshot", {30'b0, irq}, 32'd2);
        check_val("mip_oneshot", {31'b0, mip_mtip}, 32'd1);
        wr(8'h20, 32'd1000);
        idle();
        check_val("irq1_hold", {30'b0, irq}, 32'd2);
        idle();
        check_val("irq1_dropped", {30'b0, irq}, 32'd0);
        rd(8'h0C, "status_pending1", 32'd2);
        wr(8'h0C, 32'd2);
        rd(8'h0C, "status_cleared1", 32'd0);
        wr(8'h2C, 32'd0);

`ifdef TIMER_BANK_PERIODIC_EN
        // Periodic reload on channel 0
        wr(8'h00, 32'd0);
        wr(8'h10, 32'd8);
        wr(8'h14, 32'd0);
        wr(8'h18, 32'd5);
        wr(8'h1C, 32'd3);
        repeat (5) idle();
        rd(8'h10, "cmp0_reload_13", 32'd13);
        check_val("irq0_periodic_1", {30'b0, irq}, 32'd1);
        wr(8'h0C, 32'd1);
        rd(8'h0C, "status_clear_p", 32'd0);
        check_val("irq0_cleared", {30'b0, irq}, 32'd0);
        repeat (2) idle();
        rd(8'h10, "cmp0_reload_18", 32'd18);
        check_val("irq0_periodic_2", {30'b0, irq}, 32'd1);
        wr(8'h0C, 32'd1);
        idle();
        check_val("irq0_cleared_2", {30'b0, irq}, 32'd0);
        idle();
        wr(8'h0C, 32'd1);
        rd(8'h10, "cmp0_reload_23", 32'd23);
        check_val("irq0_collision", {30'b0, irq}, 32'd1);
        rd(8'h0C, "status_collision", 32'd1);
        wr(8'h1C, 32'd0);
`else
        // Periodic bit and PERIOD absent: channel 0 stays one-shot
        wr(8'h18, 32'd5);
        wr(8'h1C, 32'd3);
        rd(8'h1C, "ctrl0_no_periodic", 32'd1);
        rd(8'h18, "period0_absent", 32'd0);
        wr(8'h10, 32'd8);
        wr(8'h14, 32'd0);
        repeat (2) idle();
        check_val("irq0_oneshot", {30'b0, irq}, 32'd1);
        wr(8'h0C, 32'd1);
        rd(8'h0C, "status_collision", 32'd1);
        wr(8'h1C, 32'd0);
        wr(8'h0C, 32'd1);
        rd(8'h0C, "status_cleared0", 32'd0);
        check_val("irq0_disabled", {30'b0, irq}, 32'd0);
`endif

        // Reset while both channels interrupt, with a colliding CMP write
        wr(8'h10, 32'd0);
        wr(8'h14, 32'd0);
        wr(8'h20, 32'd0);
        wr(8'h24, 32'd0);
        wr(8'h1C, 32'd1);
        wr(8'h2C, 32'd1);
        repeat (2) idle();
        check_val("irq_both", {30'b0, irq}, 32'd3);
        @(negedge clk24);
        reset                 = 1'b1;
        memory_address        = BASE + 32'h10;
        memory_write_value    = 32'h0000_1234;
        memory_write_sections = 4'hF;
        @(negedge clk24);
        reset                 = 1'b0;
        memory_address        = 32'h0;
        memory_write_value    = 32'h0;
        memory_write_sections = 4'h0;
        check_val("irq_reset", {30'b0, irq}, 32'd0);
        check_val("mip_reset", {31'b0, mip_mtip}, 32'd0);
        check_val("read_hit_reset", {31'b0, read_hit}, 32'd0);
        check_val("read_value_reset", read_value, 32'd0);
        rd(8'h10, "cmp0_write_discarded", 32'hFFFF_FFFF);
        rd(8'h00, "mtime_after_reset", 32'd2);
        rd(8'h0C, "status_after_reset", 32'd0);
        rd(8'h1C, "ctrl0_after_reset", 32'd0);
        rd(8'h08, "prescale_after_reset", 32'd0);
        rd(8'h30, "unmapped_channel", 32'd0);

        repeat (2) idle();
        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
